tape_frame_scheduler: RTL and testbench

TAPE_FRAME_SCHEDULER -- requirements
Module: tape_frame_scheduler

---
 rtl/tape_frame_scheduler.sv | 155 +++++++++++++++
 tb/tb_tape_frame_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_frame_scheduler.sv
// tape_frame_scheduler: packs host bytes into framed 4-bit level-coded tape symbols
// (preamble, delimiters, sequence header, payload, XOR checksum) for the symbol FIFO.
module tape_frame_scheduler #(
    parameter int PRE_LEN     = 8,
    parameter int BLOCK_BYTES = 32,
    parameter int FIFO_DEPTH  = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        flush,
    output logic [3:0]  fifow_data,
    output logic        fifow_request,
    input  logic        fifow_full,
    input  logic [10:0] fifow_used_words,
    output logic [7:0]  seq_num,
    output logic        busy,
    output logic        frame_done
);
    localparam int FRAME_SYMS = PRE_LEN + 3 * BLOCK_BYTES + 8;
    localparam logic [31:0] ROOM_LIMIT = 32'(FIFO_DEPTH - FRAME_SYMS);
    localparam int CW = $clog2((PRE_LEN > BLOCK_BYTES ? PRE_LEN : BLOCK_BYTES) + 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] BYTE_LAST = CW'(BLOCK_BYTES - 1);
    localparam logic [3:0] SYM_PRE = 4'b1010;
    localparam logic [3:0] SYM_DELIM = 4'b0101;

    typedef enum logic [2:0] {IDLE, PREAMBLE, START, HEADER, PAYLOAD, CHECK, END} state_t;

    state_t        state, state_nxt;
    logic [1:0]    phase, phase_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    cur_byte, cur_byte_nxt;
    logic [7:0]    checksum, checksum_nxt;
    logic [7:0]    seq_nxt;
    logic          flush_pend, flush_pend_nxt;
    logic          wr, done_nxt, room, accept;
    logic [3:0]    sym;

    // Levels 0..4 fill a thermometer from the LSB, 5..7 drain it from the LSB.
    function automatic logic [3:0] level(input logic [2:0] v);
        return v < 3'd5 ? 4'b1111 >> (3'd4 - v) : 4'b1111 << (v - 3'd4);
    endfunction

    function automatic logic [3:0] byte_sym(input logic [7:0] b, input logic [1:0] p);
        return p == 2'd0 ? level({1'b0, b[7:6]}) : p == 2'd1 ? level(b[5:3]) : level(b[2:0]);
    endfunction

    assign room       = {21'd0, fifow_used_words} <= ROOM_LIMIT;
    assign data_ready = state == PAYLOAD && phase == 2'd0 && !fifow_full && !flush_pend;
    assign accept     = data_ready && data_valid;
    assign busy       = state != IDLE;

    always_comb begin
        state_nxt      = state;
        phase_nxt      = phase;
        cnt_nxt        = cnt;
        cur_byte_nxt   = cur_byte;
        checksum_nxt   = checksum;
        seq_nxt        = seq_num;
        done_nxt       = 1'b0;
        wr             = 1'b0;
        sym            = fifow_data;
        flush_pend_nxt = flush_pend || (state == PAYLOAD && flush);
        if (state == IDLE) begin
            state_nxt = data_valid && room ? PREAMBLE : IDLE;
        end else if (!fifow_full) begin
            // A full FIFO freezes everything except flush capture.
            case (state)
                PREAMBLE: begin
                    wr        = 1'b1;
                    sym       = SYM_PRE;
                    cnt_nxt   = cnt == PRE_LAST ? '0 : cnt + CW'(1);
                    state_nxt = cnt == PRE_LAST ? START : PREAMBLE;
                end
                START: begin
                    wr             = 1'b1;
                    sym            = SYM_DELIM;
                    checksum_nxt   = 8'd0;
                    phase_nxt      = 2'd0;
                    flush_pend_nxt = 1'b0;
                    state_nxt      = HEADER;
                end
                HEADER: begin
                    wr        = 1'b1;
                    sym       = byte_sym(seq_num, phase);
                    phase_nxt = phase == 2'd2 ? 2'd0 : phase + 2'd1;
                    state_nxt = phase == 2'd2 ? PAYLOAD : HEADER;
                end
                PAYLOAD: begin
                    if (phase == 2'd0) begin
                        if (flush_pend || accept) begin
                            wr           = 1'b1;
                            cur_byte_nxt = flush_pend ? 8'd0 : data_in;
                            sym          = byte_sym(cur_byte_nxt, 2'd0);
                            checksum_nxt = checksum ^ cur_byte_nxt;
                            phase_nxt    = 2'd1;
                        end
                    end else begin
                        wr        = 1'b1;
                        sym       = byte_sym(cur_byte, phase);
                        phase_nxt = phase == 2'd2 ? 2'd0 : phase + 2'd1;
                        if (phase == 2'd2) begin
                            cnt_nxt   = cnt == BYTE_LAST ? '0 : cnt + CW'(1);
                            state_nxt = cnt == BYTE_LAST ? CHECK : PAYLOAD;
                        end
                    end
                end
                CHECK: begin
                    wr        = 1'b1;
                    sym       = byte_sym(checksum, phase);
                    phase_nxt = phase == 2'd2 ? 2'd0 : phase + 2'd1;
                    state_nxt = phase == 2'd2 ? END : CHECK;
                end
                END: begin
                    wr             = 1'b1;
                    sym            = SYM_DELIM;
                    done_nxt       = 1'b1;
                    seq_nxt        = seq_num + 8'd1;
                    flush_pend_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            phase         <= 2'd0;
            cnt           <= '0;
            cur_byte      <= 8'd0;
            checksum      <= 8'd0;
            flush_pend    <= 1'b0;
            seq_num       <= 8'd0;
            fifow_data    <= 4'd0;
            fifow_request <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_nxt;
            phase         <= phase_nxt;
            cnt           <= cnt_nxt;
            cur_byte      <= cur_byte_nxt;
            checksum      <= checksum_nxt;
            flush_pend    <= flush_pend_nxt;
            seq_num       <= seq_nxt;
            fifow_data    <= sym;
            fifow_request <= wr;
            frame_done    <= done_nxt;
        end
    end
endmodule

// File: tb/tb_tape_frame_scheduler.sv
// tb_tape_frame_scheduler: encoding vector table, directed corner sequences and
// randomized frames checked against a whole-frame symbol model.
module tb_tape_frame_scheduler;
    localparam int PRE = 8;
    localparam int BB  = 32;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]  din;
        logic [11:0] syms;
    } vec_t;

    logic        clk = 0, rst = 0, data_valid = 0, flush = 0, fifow_full = 0;
    logic [7:0]  data_in = 0;
    logic [10:0] used = 0;
    logic        data_ready, fifow_request, busy, frame_done;
    logic [3:0]  fifow_data;
    logic [7:0]  seq_num;

    int          checks = 0, errors = 0, done_cnt = 0;
    logic [7:0]  exp_seq = 0;
    logic        full_q = 0;
    logic [3:0]  wq[$];
    logic [3:0]  eq[$];
    logic [3:0]  codes[8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    tape_frame_scheduler dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .flush(flush), .fifow_data(fifow_data), .fifow_request(fifow_request), .fifow_full(fifow_full),
        .fifow_used_words(used), .seq_num(seq_num), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) full_q <= fifow_full;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    always @(negedge clk) if (rst) begin
        if (fifow_request) wq.push_back(fifow_data);
        if (frame_done) done_cnt++;
        if (full_q) check("request after full", fifow_request, 0);
    end

    task automatic push_byte(input logic [7:0] b);
        int v;
        v = b;
        eq.push_back(codes[v / 64]);
        eq.push_back(codes[(v / 8) % 8]);
        eq.push_back(codes[v % 8]);
    endtask

    task automatic build_frame(input logic [7:0] seq, input bq_t pl);
        logic [7:0] ck, b;
        ck = 0;
        eq = {};
        repeat (PRE) eq.push_back(4'b1010);
        eq.push_back(4'b0101);
        push_byte(seq);
        for (int i = 0; i < BB; i++) begin
            b = i < pl.size() ? pl[i] : 8'h00;
            push_byte(b);
            ck ^= b;
        end
        push_byte(ck);
        eq.push_back(4'b0101);
    endtask

    task automatic check_frame(input string name, input bq_t pl, input int d0);
        int bad, first;
        bad = 0;
        first = -1;
        build_frame(exp_seq, pl);
        check({name, " length"}, wq.size(), eq.size());
        for (int i = 0; i < eq.size(); i++)
            if (i >= wq.size() || wq[i] !== eq[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s symbols: %0d wrong, first at %0d got %b expected %b", name, bad, first,
                     first < wq.size() ? wq[first] : 4'bx, eq[first]);
        end
        check({name, " frame_done pulses"}, done_cnt - d0, 1);
        exp_seq++;
        check({name, " seq_num"}, seq_num, exp_seq);
    endtask

    task automatic wait_done(input string name, input int d0);
        int g;
        g = 0;
        while (done_cnt == d0 && g < 3000) begin
            @(negedge clk);
            #1;
            if (flush === 1'b0) check({name, " ready while padding"}, data_ready, 0);
            g++;
        end
        if (g >= 3000) timeout(name);
        @(negedge clk);
    endtask

    task automatic run_frame(input string name, input bq_t src, input int flush_at,
                             input bit coincide, input bit gaps, input bit noise);
        bq_t pl;
        int  acc, guard, d0;
        bit  flushed, hs;
        pl = {};
        acc = 0;
        guard = 0;
        d0 = done_cnt;
        flushed = 0;
        wq = {};
        while (done_cnt == d0 && guard < 3000) begin
            @(negedge clk);
            guard++;
            fifow_full = noise && $urandom_range(0, 7) == 0;
            flush = 0;
            data_valid = !flushed && acc < BB && (!gaps || $urandom_range(0, 2) != 0) &&
                         (coincide || acc != flush_at);
            data_in = acc < BB ? src[acc] : 8'h00;
            #1;
            hs = data_valid && data_ready;
            if (flushed) check({name, " ready while padding"}, data_ready, 0);
            if (!flushed && flush_at > 0 && (coincide ? hs && acc + 1 == flush_at : acc == flush_at)) begin
                flush = 1;
                flushed = 1;
            end
            if (hs) begin
                pl.push_back(data_in);
                acc++;
            end
        end
        @(negedge clk);
        data_valid = 0;
        flush = 0;
        fifow_full = 0;
        if (guard >= 3000) timeout(name);
        check_frame(name, pl, d0);
    endtask

    task automatic rand_src(output bq_t q);
        q = {};
        for (int i = 0; i < BB; i++) q.push_back(8'($urandom));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt[10];
        bq_t         src, pl;
        int          g, d0, n, target;
        logic [11:0] got;

        vt[0] = '{8'hFF, 12'h788};
        vt[1] = '{8'hA5, 12'h3FE};
        vt[2] = '{8'h00, 12'h000};
        vt[3] = '{8'h1F, 12'h078};
        vt[4] = '{8'h80, 12'h300};
        vt[5] = '{8'h49, 12'h111};
        vt[6] = '{8'h36, 12'h0CC};
        vt[7] = '{8'h12, 12'h033};
        vt[8] = '{8'h40, 12'h100};
        vt[9] = '{8'hC7, 12'h708};

        repeat (3) @(negedge clk);
        #1;
        check("reset request", fifow_request, 0);
        check("reset data", fifow_data, 0);
        check("reset ready", data_ready, 0);
        check("reset busy", busy, 0);
        check("reset frame_done", frame_done, 0);
        check("reset seq_num", seq_num, 0);
        @(negedge clk);
        rst = 1;

        src = {};
        for (int i = 0; i < BB; i++) src.push_back(8'(i));
        run_frame("ramp frame", src, -1, 0, 0, 0);

        // Encoding vectors: each accepted byte must show its three symbols on the next three cycles.
        wq = {};
        pl = {};
        d0 = done_cnt;
        foreach (vt[i]) begin
            @(negedge clk);
            data_in = vt[i].din;
            data_valid = 1;
            g = 0;
            #1;
            while (!data_ready && g < 200) begin
                @(negedge clk);
                #1;
                g++;
            end
            if (g >= 200) timeout("vector accept");
            pl.push_back(vt[i].din);
            got = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                data_valid = 0;
                #1;
                got = {got[7:0], fifow_request ? fifow_data : 4'bx};
            end
            check($sformatf("encode %02h", vt[i].din), got, vt[i].syms);
        end
        @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        wait_done("vector frame", d0);
        check_frame("vector frame", pl, d0);

        // FIFO room threshold at the IDLE decision.
        @(negedge clk);
        used = 11'd1937;
        data_valid = 1;
        data_in = 8'h5A;
        wq = {};
        repeat (20) @(negedge clk);
        #1;
        check("room 1937 busy", busy, 0);
        check("room 1937 writes", wq.size(), 0);
        used = 11'd1936;
        @(negedge clk);
        #1;
        check("room 1936 busy", busy, 1);
        rand_src(src);
        run_frame("room 1936 frame", src, -1, 0, 0, 0);
        used = 0;

        rand_src(src);
        run_frame("flush after 5", src, 5, 0, 0, 0);
        rand_src(src);
        run_frame("flush with handshake", src, 5, 1, 0, 0);
        rand_src(src);
        run_frame("flush on last byte", src, BB - 1, 0, 1, 0);

        for (int r = 0; r < 6; r++) begin
            rand_src(src);
            run_frame($sformatf("random frame %0d", r), src,
                      $urandom_range(0, 2) == 0 ? -1 : int'($urandom_range(1, BB - 1)),
                      1'($urandom_range(0, 1)), 1, 1'(r % 2));
        end

        // Reset in PAYLOAD byte phase 1, then a clean restart.
        @(negedge clk);
        data_in = 8'h3C;
        data_valid = 1;
        g = 0;
        #1;
        while (!data_ready && g < 200) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 200) timeout("reset accept");
        @(negedge clk);
        data_valid = 0;
        rst = 0;
        #1;
        check("mid-frame reset request", fifow_request, 0);
        check("mid-frame reset busy", busy, 0);
        check("mid-frame reset seq_num", seq_num, 0);
        check("mid-frame reset ready", data_ready, 0);
        exp_seq = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        data_valid = 1;
        @(negedge clk);
        #1;
        check("first write after release", fifow_request, 0);
        check("busy after release", busy, 1);
        rand_src(src);
        run_frame("frame after reset", src, -1, 0, 0, 0);

        // Sequence wrap: run frames until seq_num should read 255.
        target = 255 - int'(exp_seq);
        n = 0;
        g = 0;
        data_in = 8'h00;
        data_valid = 1;
        while (n < target && g < 40000) begin
            @(negedge clk);
            g++;
            if (frame_done) n++;
        end
        data_valid = 0;
        if (g >= 40000) timeout("wrap frames");
        exp_seq = exp_seq + 8'(target);
        repeat (3) @(negedge clk);
        #1;
        check("seq before wrap", seq_num, exp_seq);
        check("idle before wrap", busy, 0);
        rand_src(src);
        run_frame("wrap frame", src, -1, 0, 1, 0);
        check("wrap header", wq.size() > PRE + 3 ? {wq[PRE + 1], wq[PRE + 2], wq[PRE + 3]} : 12'hxxx, 12'h788);
        check("seq after wrap", seq_num, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
